// File: rtl/data_resp_pkg.sv
// Shared constants and helpers for the data SRAM responder and its confreg window.
package data_resp_pkg;

    localparam logic [31:0] CONF_BASE_DEF = 32'hbfaf_0000;
    localparam logic [31:0] CONF_MASK_DEF = 32'hffff_0000;

    localparam logic [15:0] OFF_TIMER   = 16'h8000;
    localparam logic [15:0] OFF_LED     = 16'hf000;
    localparam logic [15:0] OFF_SWITCH  = 16'hf010;
    localparam logic [15:0] OFF_SCRATCH = 16'hf020;
    localparam logic [15:0] OFF_CMP     = 16'hf030;
    localparam logic [15:0] OFF_ACK     = 16'hf034;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  we);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_resp_confreg.sv
// Configuration registers: free-running timer, compare interrupt, LED, switch sample, scratch.
// Instantiated only when DATA_RESP_CONFREG_EN is defined.
module data_resp_confreg
    import data_resp_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        acc,
    input  logic [3:0]  we,
    input  logic [13:0] word_off,
    input  logic [31:0] wdata,
    input  logic [7:0]  switch_in,
    output logic [31:0] rdata,
    output logic [15:0] led_out,
    output logic        timer_int
);

    logic [31:0] timer;
    logic [31:0] cmp;
    logic [31:0] scratch;
    logic [15:0] led;
    logic [7:0]  sw;
    logic        wr;
    logic        sel_timer, sel_led, sel_switch, sel_scratch, sel_cmp, sel_ack;
    logic [31:0] led_merged;
    logic [31:0] rd_mux;

    assign wr          = acc && (we != 4'b0000);
    assign sel_timer   = (word_off == OFF_TIMER[15:2]);
    assign sel_led     = (word_off == OFF_LED[15:2]);
    assign sel_switch  = (word_off == OFF_SWITCH[15:2]);
    assign sel_scratch = (word_off == OFF_SCRATCH[15:2]);
    assign sel_cmp     = (word_off == OFF_CMP[15:2]);
    assign sel_ack     = (word_off == OFF_ACK[15:2]);
    assign led_merged  = lane_merge({16'h0000, led}, wdata, we);

    always_comb begin
        rd_mux = 32'h0000_0000;
        if (sel_timer)        rd_mux = timer;
        else if (sel_led)     rd_mux = {16'h0000, led};
        else if (sel_switch)  rd_mux = {24'h00_0000, sw};
        else if (sel_scratch) rd_mux = scratch;
        else if (sel_cmp)     rd_mux = cmp;
        else if (sel_ack)     rd_mux = {31'h0, timer_int};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer     <= 32'h0;
            cmp       <= 32'h0;
            scratch   <= 32'h0;
            led       <= 16'h0;
            sw        <= 8'h0;
            timer_int <= 1'b0;
            rdata     <= 32'h0;
        end else begin
            sw <= switch_in;
            // A software load takes priority over the free-running increment.
            timer <= (wr && sel_timer) ? lane_merge(timer, wdata, we) : timer + 32'd1;
            if (wr && sel_led)     led     <= led_merged[15:0];
            if (wr && sel_scratch) scratch <= lane_merge(scratch, wdata, we);
            if (wr && sel_cmp)     cmp     <= lane_merge(cmp, wdata, we);
            // A fresh match beats a simultaneous acknowledge.
            if ((timer == cmp) && (cmp != 32'h0)) timer_int <= 1'b1;
            else if (wr && sel_ack)               timer_int <= 1'b0;
            if (acc) rdata <= rd_mux;
        end
    end

    assign led_out = led;

endmodule

// File: rtl/data_sram_resp.sv
// Data-port memory responder: byte-writable word RAM with read-first, single-cycle reads.
// The confreg window is decoded only when DATA_RESP_CONFREG_EN is defined.
module data_sram_resp
    import data_resp_pkg::*;
#(
    parameter int          RAM_AW    = 16,
    parameter logic [31:0] CONF_BASE = CONF_BASE_DEF,
    parameter logic [31:0] CONF_MASK = CONF_MASK_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic        timer_int
);

    logic [31:0]       mem [2**RAM_AW];
    logic [RAM_AW-1:0] idx;
    logic              conf_hit;
    logic              ram_acc;
    logic              ram_wr;
    logic [31:0]       ram_q;
    logic              unused_bits;

    assign idx         = data_sram_addr[RAM_AW+1:2];
    assign unused_bits = ^{data_sram_addr, switch_in};

`ifdef DATA_RESP_CONFREG_EN
    logic        conf_hit_q;
    logic [31:0] conf_rdata;

    assign conf_hit = ((data_sram_addr & CONF_MASK) == CONF_BASE);

    data_resp_confreg u_confreg (
        .clk       (clk),
        .resetn    (resetn),
        .acc       (data_sram_en && conf_hit),
        .we        (data_sram_we),
        .word_off  (data_sram_addr[15:2]),
        .wdata     (data_sram_wdata),
        .switch_in (switch_in),
        .rdata     (conf_rdata),
        .led_out   (led_out),
        .timer_int (timer_int)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)           conf_hit_q <= 1'b0;
        else if (data_sram_en) conf_hit_q <= conf_hit;
    end

    assign data_sram_rdata = conf_hit_q ? conf_rdata : ram_q;
`else
    assign conf_hit        = 1'b0;
    assign led_out         = 16'h0000;
    assign timer_int       = 1'b0;
    assign data_sram_rdata = ram_q;
`endif

    assign ram_acc = data_sram_en && !conf_hit;
    // Gate with resetn so an access caught by reset leaves the array untouched.
    assign ram_wr  = ram_acc && (data_sram_we != 4'b0000) && resetn;

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) mem[idx][i*8 +: 8] <= data_sram_wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      ram_q <= 32'h0;
        else if (ram_acc) ram_q <= mem[idx];
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed self-checking bench for data_sram_resp; confreg checks run when DATA_RESP_CONFREG_EN is defined.
module tb_data_sram_resp;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  switch_in;
    logic [15:0] led_out;
    logic        timer_int;

    int n_cmp = 0;
    int n_bad = 0;

    data_sram_resp dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .switch_in       (switch_in),
        .led_out         (led_out),
        .timer_int       (timer_int)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request cycle; returns 1 time unit after the edge, when the response is visible.
    task automatic acc(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        en = 1'b0; we = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a);
        acc(4'h0, a, 32'h0);
    endtask

    task automatic idle();
        en = 1'b0; we = 4'h0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0; switch_in = 8'h00;
        #12;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_led", {16'h0, led_out}, 32'h0);
        chk("rst_int", {31'h0, timer_int}, 32'h0);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;

        // RAM: basic read, hold, read-first lane merge, back-to-back, latency, wrap
        acc(4'hf, 32'h1c00_0000, 32'hdead_beef);
        rd(32'h1c00_0000);
        chk("ram_rd", rdata, 32'hdead_beef);
        idle();
        chk("ram_hold", rdata, 32'hdead_beef);
        acc(4'hf, 32'h1c00_0004, 32'haabb_ccdd);
        acc(4'b0101, 32'h1c00_0004, 32'h1122_3344);
        chk("ram_read_first", rdata, 32'haabb_ccdd);
        rd(32'h1c00_0004);
        chk("ram_lanes", rdata, 32'haa22_cc44);
        acc(4'hf, 32'h1c00_0008, 32'hcafe_f00d);
        rd(32'h1c00_0008);
        chk("ram_b2b", rdata, 32'hcafe_f00d);
        rd(32'h1c00_0000);
        chk("ram_lat0", rdata, 32'hdead_beef);
        rd(32'h1c00_0004);
        chk("ram_lat1", rdata, 32'haa22_cc44);
        rd(32'h1c04_0000);
        chk("ram_wrap", rdata, 32'hdead_beef);

`ifdef DATA_RESP_CONFREG_EN
        // Timer load beats increment and wraps: fffffffe, ffffffff, 0, 1
        acc(4'hf, 32'hbfaf_8000, 32'hffff_fffe);
        idle(); idle(); idle();
        rd(32'hbfaf_8000);
        chk("timer_wrap", rdata, 32'h0000_0001);

        // Compare interrupt: timer=0x100 in the cycle cmp=0x105 is written
        acc(4'hf, 32'hbfaf_8000, 32'h0000_0100);
        acc(4'hf, 32'hbfaf_f030, 32'h0000_0105);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("int_early", {31'h0, timer_int}, 32'h0);
        end
        idle();
        chk("int_rise", {31'h0, timer_int}, 32'h1);
        // timer is 0x106 here; next match at 0x10a, four cycles on
        acc(4'hf, 32'hbfaf_f030, 32'h0000_010a);
        rd(32'hbfaf_f034);
        chk("ack_read", rdata, 32'h1);
        idle(); idle();
        chk("int_sticky", {31'h0, timer_int}, 32'h1);
        acc(4'hf, 32'hbfaf_f034, 32'h0);
        chk("int_set_wins", {31'h0, timer_int}, 32'h1);
        acc(4'hf, 32'hbfaf_f034, 32'h0);
        chk("int_ack", {31'h0, timer_int}, 32'h0);

        // Switch, LED, scratch, unmapped
        switch_in = 8'h5a;
        acc(4'hf, 32'hbfaf_f000, 32'h1234_abcd);
        chk("led_out", {16'h0, led_out}, 32'h0000_abcd);
        rd(32'hbfaf_f010);
        chk("switch_rd", rdata, 32'h0000_005a);
        rd(32'hbfaf_f000);
        chk("led_rd", rdata, 32'h0000_abcd);
        acc(4'hf, 32'hbfaf_f010, 32'hffff_ffff);
        rd(32'hbfaf_f010);
        chk("switch_ro", rdata, 32'h0000_005a);
        acc(4'b0011, 32'hbfaf_f020, 32'hdead_beef);
        acc(4'hf, 32'hbfaf_f020, 32'h7777_7777);
        chk("scratch_read_first", rdata, 32'h0000_beef);
        rd(32'hbfaf_f020);
        chk("scratch_rd", rdata, 32'h7777_7777);
        acc(4'hf, 32'hbfaf_f040, 32'h1234_5678);
        rd(32'hbfaf_f040);
        chk("unmapped", rdata, 32'h0);
`else
        // Without the window, 0xbfaf8000 is plain RAM (index addr[17:2] = 0xe000)
        acc(4'hf, 32'h1c03_8000, 32'h0123_4567);
        acc(4'hf, 32'hbfaf_8000, 32'h5555_aaaa);
        chk("alias_read_first", rdata, 32'h0123_4567);
        rd(32'h1c03_8000);
        chk("alias_ram", rdata, 32'h5555_aaaa);
        acc(4'hf, 32'hbfaf_f000, 32'h1234_abcd);
        chk("led_tied", {16'h0, led_out}, 32'h0);
        rd(32'h0003_f000);
        chk("led_addr_ram", rdata, 32'h1234_abcd);
        chk("int_tied", {31'h0, timer_int}, 32'h0);
`endif

        // Reset during a pending write: rdata clears immediately, RAM untouched
        acc(4'hf, 32'h1c00_000c, 32'h1234_5678);
        rd(32'h1c00_0004);
        chk("pre_rst_rd", rdata, 32'haa22_cc44);
        en = 1'b1; we = 4'hf; addr = 32'h1c00_000c; wdata = 32'hbad0_bad0;
        #2 resetn = 1'b0;
        #1;
        chk("rst_async_rdata", rdata, 32'h0);
        chk("rst_async_led", {16'h0, led_out}, 32'h0);
        @(posedge clk); #1;
        chk("rst_hold_rdata", rdata, 32'h0);
        en = 1'b0; we = 4'h0;
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        rd(32'h1c00_000c);
        chk("rst_no_write", rdata, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
